// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: groups the FIFO read-side handshake and the UART/status
// outputs of fifo_uart_tx. The master modport is the transmitter; the slave
// modport is the FIFO and observer side.
interface fifo_uart_tx_if;
   logic        fifo_empty;
   logic [7:0]  fifo_data;
   logic        fifo_rd;
   logic        tx;
   logic        busy;
   logic        frame_done;
   logic [15:0] frame_cntr;

   modport master (
      input  fifo_empty, fifo_data,
      output fifo_rd, tx, busy, frame_done, frame_cntr
   );

   modport slave (
      output fifo_empty, fifo_data,
      input  fifo_rd, tx, busy, frame_done, frame_cntr
   );
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pulls one byte at a time from a registered-output FIFO and
// sends it as an async UART frame (start, 8 data bits LSB first, stop).
// Optional feature macro FIFO_TX_PARITY_EN adds an even-parity bit (8E1);
// without it the frame is 8N1.
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 16
) (
   input logic            clk,
   input logic            rst,
   fifo_uart_tx_if.master bus
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      START,
      DATA,
`ifdef FIFO_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          rd_q, rd_d;
   logic          tx_q, tx_d;
   logic [15:0]   cntr_q, cntr_d;
`ifdef FIFO_TX_PARITY_EN
   logic          par_q, par_d;
`endif
   logic          tick;

   assign tick           = (cnt_q == CNT_LAST);
   assign bus.fifo_rd    = rd_q;
   assign bus.tx         = tx_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.frame_done = (state_q == STOP) && tick;
   assign bus.frame_cntr = cntr_q;

   // Next-state, baud/bit counters, shifter and registered-output inputs.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      rd_d      = 1'b0;
      cntr_d    = cntr_q;
`ifdef FIFO_TX_PARITY_EN
      par_d     = par_q;
`endif
      case (state_q)
         IDLE: begin
            // Read strobe is raised only on a sampled non-empty FIFO.
            if (!bus.fifo_empty) begin
               state_d = FETCH;
               rd_d    = 1'b1;
            end
         end
         FETCH: state_d = WAIT;
         WAIT: begin
            // Only state in which the FIFO read bus is looked at.
            shift_d   = bus.fifo_data;
`ifdef FIFO_TX_PARITY_EN
            par_d     = ^bus.fifo_data;
`endif
            bit_idx_d = '0;
            cnt_d     = '0;
            state_d   = START;
         end
         START: begin
            if (tick) begin
               cnt_d   = '0;
               state_d = DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DATA: begin
            if (tick) begin
               cnt_d     = '0;
               shift_d   = {1'b0, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
`ifdef FIFO_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
`ifdef FIFO_TX_PARITY_EN
         PARITY: begin
            if (tick) begin
               cnt_d   = '0;
               state_d = STOP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
`endif
         STOP: begin
            if (tick) begin
               cnt_d   = '0;
               cntr_d  = cntr_q + 16'd1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // tx is registered, so it is derived from where we are heading.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
`ifdef FIFO_TX_PARITY_EN
         PARITY:  tx_d = par_d;
`endif
         default: tx_d = 1'b1;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         rd_q      <= 1'b0;
         tx_q      <= 1'b1;
         cntr_q    <= '0;
`ifdef FIFO_TX_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         rd_q      <= rd_d;
         tx_q      <= tx_d;
         cntr_q    <= cntr_d;
`ifdef FIFO_TX_PARITY_EN
         par_q     <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed bench for fifo_uart_tx with CLKS_PER_BIT=4 and a
// small registered-output FIFO model. Outputs are sampled on falling edges.
module tb_fifo_uart_tx;

   localparam int N = 4;
`ifdef FIFO_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fifo_uart_tx_if ifc ();

   fifo_uart_tx #(.CLKS_PER_BIT(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   // FIFO model: data appears the cycle after a sampled read; junk otherwise.
   logic [7:0] mem [0:63];
   int         wr_ptr = 0;
   int         rd_ptr = 0;
   logic [7:0] fdata = 8'h00;
   int         rd_pulses = 0;
   int         proto_err = 0;
   bit         rd_prev = 1'b0;

   assign ifc.fifo_empty = (wr_ptr == rd_ptr);
   assign ifc.fifo_data  = fdata;

   always @(posedge clk) begin
      if (ifc.fifo_rd) begin
         rd_pulses++;
         if (rd_prev) proto_err++;
         if (wr_ptr == rd_ptr) begin
            proto_err++;
            fdata <= 8'($urandom);
         end else begin
            fdata  <= mem[rd_ptr % 64];
            rd_ptr <= rd_ptr + 1;
         end
      end else begin
         fdata <= 8'($urandom);
      end
      rd_prev <= ifc.fifo_rd;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_ptr % 64] = b;
      wr_ptr++;
   endtask

   // Entered at a falling edge in IDLE with the FIFO non-empty; returns at the
   // falling edge of the IDLE cycle that follows the stop bit.
   task automatic frame(input logic [7:0] b, input logic par, input int exp_cnt,
                        input string nm);
      logic exp_bit [NB];
      int   errs;
      int   fd_err;
      exp_bit[0] = 1'b0;
      for (int i = 0; i < 8; i++) exp_bit[1+i] = b[i];
`ifdef FIFO_TX_PARITY_EN
      exp_bit[9] = par;
`else
      if (par === 1'bx) exp_bit[0] = 1'b0;
`endif
      exp_bit[NB-1] = 1'b1;

      @(negedge clk);
      chk({nm, " fetch rd/busy/tx"}, int'({ifc.fifo_rd, ifc.busy, ifc.tx}), 7);
      @(negedge clk);
      chk({nm, " wait rd/busy/tx"}, int'({ifc.fifo_rd, ifc.busy, ifc.tx}), 3);
      fd_err = 0;
      for (int k = 0; k < NB; k++) begin
         errs = 0;
         for (int c = 0; c < N; c++) begin
            @(negedge clk);
            if (ifc.tx !== exp_bit[k] || ifc.busy !== 1'b1) errs++;
            if (ifc.frame_done !== ((k == NB-1) && (c == N-1))) fd_err++;
         end
         chk($sformatf("%s bit%0d bad samples", nm, k), errs, 0);
      end
      chk({nm, " frame_done pulse"}, fd_err, 0);
      @(negedge clk);
      chk({nm, " idle busy/tx/done"}, int'({ifc.busy, ifc.tx, ifc.frame_done}), 2);
      chk({nm, " frame_cntr"}, int'(ifc.frame_cntr), exp_cnt);
   endtask

   typedef struct {
      logic [7:0] data;
      logic       par;
   } vec_t;

   vec_t vt [5];
   int   bad;

   initial begin
      vt[0] = '{data: 8'h00, par: 1'b0};
      vt[1] = '{data: 8'hFF, par: 1'b0};
      vt[2] = '{data: 8'h55, par: 1'b0};
      vt[3] = '{data: 8'h07, par: 1'b1};
      vt[4] = '{data: 8'h03, par: 1'b0};

      // Reset held with a non-empty FIFO: no read strobe, idle outputs.
      @(negedge clk);
      push(8'hA5);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("reset%0d rd/busy/tx/done", i),
             int'({ifc.fifo_rd, ifc.busy, ifc.tx, ifc.frame_done}), 2);
         chk($sformatf("reset%0d frame_cntr", i), int'(ifc.frame_cntr), 0);
      end
      chk("reset rd pulses", rd_pulses, 0);
      rst = 1'b0;

      // Single byte.
      frame(8'hA5, 1'b0, 1, "A5");
      chk("single rd pulses", rd_pulses, 1);

      // Back-to-back frames from a pre-filled FIFO.
      for (int i = 0; i < 5; i++) push(vt[i].data);
      for (int i = 0; i < 5; i++)
         frame(vt[i].data, vt[i].par, 2 + i, $sformatf("vec%0d", i));
      chk("b2b rd pulses", rd_pulses, 6);

      // Reset during data bit 3; the in-flight byte is dropped, next one intact.
      push(8'h3C);
      push(8'hC3);
      @(negedge clk);
      @(negedge clk);
      repeat (N + 3*N + 1) @(negedge clk);
      chk("midframe tx in bit3", int'(ifc.tx), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst rd/busy/tx/done",
          int'({ifc.fifo_rd, ifc.busy, ifc.tx, ifc.frame_done}), 2);
      chk("midrst frame_cntr", int'(ifc.frame_cntr), 0);
      rst = 1'b0;
      frame(8'hC3, 1'b0, 1, "C3");
      chk("midrst rd pulses", rd_pulses, 8);

      // Starvation.
      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (ifc.fifo_rd !== 1'b0 || ifc.tx !== 1'b1 || ifc.busy !== 1'b0) bad++;
      end
      chk("starve bad cycles", bad, 0);
      chk("starve rd pulses", rd_pulses, 8);
      chk("rd protocol errors", proto_err, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Drains bytes from the 64-deep single-clock FIFO and serialises each one as an asynchronous UART frame on `tx`. The block sits on the read side of the FIFO. It raises `rd` only when `empty` is low, captures the FIFO's registered read data one cycle later, then shifts the data out LSB first. It also provides a busy flag, a per-frame done pulse and a frame counter for software and debug.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clocks per serial bit. Legal range is ≥ 2. The baud counter width is $clog2(CLKS_PER_BIT).

Ports:
- `clk`, in, 1: the single clock; every register is on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `fifo_empty`, in, 1: the FIFO's `empty_reg`.
- `fifo_data`, in, 8: the FIFO's `buf_out`. It is valid only in the cycle after a `rd` was sampled, and may be Z at other times.
- `fifo_rd`, out, 1: FIFO read strobe. Registered, and always a single-cycle pulse.
- `tx`, out, 1: serial line. Registered, idle high.
- `busy`, out, 1: high whenever the state is not IDLE.
- `frame_done`, out, 1: one-cycle pulse in the last cycle of the stop bit.
- `frame_cntr`, out, 16: count of completed frames. Wraps from 0xFFFF to 0x0000.

## Operation
The state machine has states IDLE, FETCH, WAIT, START, DATA, PARITY (present only with the configuration macro) and STOP.

- **IDLE:** `tx`=1.
  - If `fifo_empty`=0 at the clock edge, go to FETCH and set `fifo_rd`=1.
- **FETCH:** lasts one cycle with `fifo_rd`=1.
  - The FIFO samples `rd` at the closing edge of this cycle.
  - Next state is WAIT, with `fifo_rd` cleared.
- **WAIT:** lasts one cycle. `fifo_data` is valid during this cycle.
  - At the closing edge: shift register ← `fifo_data`, bit index ← 0, baud counter ← 0.
  - Next state is START.
- **START:** `tx`=0 for CLKS_PER_BIT cycles.
- **DATA:** `tx`=shift[0] for CLKS_PER_BIT cycles per bit.
  - At each bit end: shift right by one and increment the bit index.
  - After bit 7, go to PARITY if the macro is enabled, otherwise STOP.
- **PARITY:** `tx`= XOR of the 8 captured bits (even parity), for CLKS_PER_BIT cycles.
- **STOP:** `tx`=1 for CLKS_PER_BIT cycles.
  - In the last cycle: `frame_done`=1. At its closing edge, `frame_cntr` increments.
  - Next state is always IDLE.

Baud counter:
- Counts 0 to CLKS_PER_BIT−1.
- The terminal count advances the bit or state and reloads the counter to 0.

Boundary conditions:
- **Empty FIFO:** the block stays in IDLE with `fifo_rd`=0 indefinitely. `fifo_rd` is never asserted while `fifo_empty`=1 is sampled.
- **FIFO fills during a frame:** no effect. The block reads exactly one byte per frame.
- **Z on `fifo_data` outside WAIT:** ignored. The bus is never sampled in any other state.
- **Reset mid-operation, any state:** at the next edge the block returns to IDLE with all outputs at reset values. An in-flight byte is discarded and is not re-read.
- **`rst` and `fifo_empty`=0 together:** reset wins, and `fifo_rd` stays 0.

Reset values:
- `tx`=1, `fifo_rd`=0, `busy`=0, `frame_done`=0, `frame_cntr`=0.
- Internal shift register, bit index and baud counter are all 0.

## Timing
- Edge E0 is the edge that samples `fifo_empty`=0 in IDLE.
  - `fifo_rd` is high from E0 to E1.
  - Data is captured at E2.
  - `tx` falls after E2.
  - Latency from empty→0 to start bit is therefore 3 edges.
- Frame length:
  - 10·CLKS_PER_BIT cycles without parity.
  - 11·CLKS_PER_BIT cycles with parity.
- Back-to-back frames: STOP → IDLE → FETCH → WAIT. This gives exactly 3 extra high cycles between the end of one stop bit and the next start bit.
- `busy` rises at E0 and falls on the edge leaving STOP.

## Configuration
- `FIFO_TX_PARITY_EN` defined: the PARITY state is compiled in. Frames are 11 bits with even parity.
- `FIFO_TX_PARITY_EN` undefined: the PARITY state and its logic are absent. Frames are 8N1.

## Test plan
- **Reset:** hold `rst` for 3 cycles with `fifo_empty`=0 → `tx`=1, `fifo_rd`=0, `busy`=0, `frame_cntr`=0, with no read pulse during reset.
- **Single byte, CLKS_PER_BIT=4:** push 0xA5 → one `fifo_rd` pulse; `tx` low 3 edges after empty falls; `tx` bits 1,0,1,0,0,1,0,1 for 4 cycles each; stop high for 4 cycles; one `frame_done` pulse; `frame_cntr`=1.
- **Back-to-back, CLKS_PER_BIT=4:** bytes 0x00, 0xFF, 0x55 → exactly 3 `fifo_rd` pulses; exactly 3 high cycles between each stop bit and the next start bit; bytes decode correctly; `frame_cntr`=3.
- **Reset mid-frame:** assert `rst` during data bit 3 → `tx`=1 and `busy`=0 on the next edge; `frame_cntr` stays 0; no extra `fifo_rd`; after release the next queued byte is sent intact.
- **Parity (`FIFO_TX_PARITY_EN`):** byte 0x07 → parity bit 1, then 0x03 → parity bit 0; each frame is 11·CLKS_PER_BIT cycles.
- **Starvation:** `fifo_empty`=1 for 1000 cycles → `fifo_rd` never asserts, `tx` stays 1, `busy` stays 0.
